bnn_frame_loader: RTL and testbench
===================================

Name: bnn_frame_loader

Overview:
- Upstream stage of the BNN top: accepts a serial stream of 8-bit grayscale pixels from the capture/host interface.
- Binarises each pixel against a programmable threshold and assembles one 1x8x8 binary frame.
- Presents the frame as a stable parallel layer vector to the BNN input, with a valid/ready handshake.
- Owns frame alignment (start-of-frame), back-pressure and frame-error reporting.

Parameters:
- CH, 1, input channels (fixed 1; index kept for the layer shape)
- ROWS, 8, frame rows
- COLS, 8, frame columns
- PIX_W, 8, grayscale pixel width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- pix_data_i  in  PIX_W  grayscale pixel
- pix_sof_i  in  1  qualifies pix_data_i as pixel 0 of a frame
- pix_valid_i  in  1  pixel valid
- pix_ready_o  out  1  loader can accept a pixel
- threshold_i  in  PIX_W  binarisation threshold
- layer_o  out  CH*ROWS*COLS  binary frame, shape [CH-1:0][ROWS-1:0][COLS-1:0]; bit [0][r][c] = pixel r*COLS+c
- layer_valid_o  out  1  frame complete and held
- layer_ready_i  in  1  BNN consumer accepts frame
- frame_err_o  out  1  one-cycle pulse: partial frame discarded
- frame_cnt_o  out  8  delivered-frame counter, wraps 255->0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=FILL, pixel index=0
  - layer_o=0, layer_valid_o=0, pix_ready_o=1, frame_err_o=0, frame_cnt_o=0
  - latched threshold=0
- Pixel accept: occurs on pix_valid_i && pix_ready_o.
- Binarisation: bit = (pix_data_i >= thr), unsigned compare.
  - thr = threshold_i, sampled on acceptance of index 0 and held for the remaining 63 pixels.
  - Mid-frame changes to threshold_i are ignored.
- FSM states:
  - FILL: pix_ready_o=1.
    - Accepted pixel writes bit at the current index; index increments.
    - On acceptance of index ROWS*COLS-1, go to HOLD.
  - HOLD: pix_ready_o=0, layer_valid_o=1, layer_o frozen.
    - On layer_valid_o && layer_ready_i: frame_cnt_o++, index=0, go to FILL; pix_ready_o=1 the following cycle.
- Latency: layer_valid_o rises the cycle after the 64th pixel is accepted. Minimum frame period is 65 cycles (64 fill + 1 handshake).
- Alignment:
  - pix_sof_i with an accepted pixel forces that pixel to index 0 and resamples the threshold.
  - If index != 0 at that moment: the partial frame is dropped, frame_err_o pulses for one cycle, and filling restarts at this pixel.
  - pix_sof_i without pix_valid_i is ignored.
  - Pixels accepted while index=0 without pix_sof_i are accepted as index 0; sof is optional for the first frame.
- Handshake rules:
  - layer_o and layer_valid_o do not change while valid && !ready.
  - layer_ready_i is ignored when layer_valid_o=0.
  - pix_ready_o does not depend combinationally on pix_valid_i.
- layer_o holds the last delivered frame after handshake until bits are overwritten. The consumer samples it only while valid.
- Reset mid-frame or mid-HOLD returns immediately to the reset values; no error pulse.

Optional Feature:
- Macro: BNN_LOADER_DBUF_EN
- With the macro: two frame buffers (fill buffer and output buffer).
  - pix_ready_o stays 1 during HOLD, so the next frame fills while the current one is held.
  - If the fill completes while the output is still unconsumed, the loader stalls with pix_ready_o=0 on the last pixel until the handshake.
  - Handshake and completion in the same cycle swaps buffers with no bubble: layer_valid_o stays 1 and the new frame appears next cycle.
  - Steady-state throughput is 64 cycles/frame.
- Without the macro: single buffer, exactly as described in Behaviour.

Decomposition:
- Shared package bnn_pkg:
  - localparams CH, ROWS, COLS, PIX_W, FRAME_BITS=CH*ROWS*COLS
  - typedef layer_in_t = logic [CH-1:0][ROWS-1:0][COLS-1:0]
  - typedef pix_t
  - enum loader_state_e {FILL, HOLD}
- One sub-module: bnn_binariser, the registered threshold latch plus comparator (pixel, threshold, sample strobe -> bit).

Test Plan:
- After reset, stream 64 pixels 0..63 with threshold 32, sof on the first, layer_ready_i=1 -> layer_valid_o the cycle after pixel 63; bits 0..31=0, bits 32..63=1; frame_cnt_o=1.
- Hold layer_ready_i=0 for 20 cycles after a frame completes -> pix_ready_o=0, layer_o stable, no pixels lost; ready=1 -> frame_cnt_o increments and pix_ready_o=1 the next cycle.
- Send 10 pixels, then a sof pixel of value 0xFF with threshold 0x80 -> frame_err_o pulses once; the next frame completes with bit[0][0][0]=1 after 63 further pixels.
- Change threshold_i from 0x10 to 0xF0 at pixel 5 on a stream of all 0x80 -> all 64 bits=1, because the threshold was latched at 0x10.
- Assert rst_ni low at pixel 40 and at mid-HOLD -> all outputs return to reset values; the next full frame is delivered correctly.
- With BNN_LOADER_DBUF_EN, stream 3 back-to-back frames with layer_ready_i=1 -> valid frames every 64 cycles, pix_ready_o never drops, frame_cnt_o=3.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and sizes for the BNN front end.
//   CH/ROWS/COLS/PIX_W  input layer shape and grayscale pixel width
//   FRAME_BITS          bits in one binary input layer
//   layer_in_t          packed layer, bit [0][r][c] is pixel r*COLS+c
//   pix_t               one grayscale pixel
//   pix_idx_t           pixel index within a frame
//   loader_state_e      frame loader FSM states
package bnn_pkg;

  localparam int CH         = 1;
  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int PIX_W      = 8;
  localparam int FRAME_BITS = CH * ROWS * COLS;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int CNT_W      = 8;

  typedef logic [CH-1:0][ROWS-1:0][COLS-1:0] layer_in_t;
  typedef logic [PIX_W-1:0]                  pix_t;
  typedef logic [IDX_W-1:0]                  pix_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/bnn_frame_loader_if.sv
// bnn_frame_loader_if: pixel stream in, binary layer out.
//   pix_data_i/pix_sof_i/pix_valid_i/pix_ready_o  grayscale pixel stream
//   threshold_i                                   binarisation threshold
//   layer_o/layer_valid_o/layer_ready_i           frame handshake to the BNN
//   frame_err_o                                   partial frame dropped pulse
//   frame_cnt_o                                   delivered frame counter
// Modports: slave = the loader, master = the source/consumer side.
interface bnn_frame_loader_if;
  import bnn_pkg::*;

  pix_t             pix_data_i;
  logic             pix_sof_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  pix_t             threshold_i;
  layer_in_t        layer_o;
  logic             layer_valid_o;
  logic             layer_ready_i;
  logic             frame_err_o;
  logic [CNT_W-1:0] frame_cnt_o;

  modport slave (
    input  pix_data_i, pix_sof_i, pix_valid_i, threshold_i, layer_ready_i,
    output pix_ready_o, layer_o, layer_valid_o, frame_err_o, frame_cnt_o
  );

  modport master (
    output pix_data_i, pix_sof_i, pix_valid_i, threshold_i, layer_ready_i,
    input  pix_ready_o, layer_o, layer_valid_o, frame_err_o, frame_cnt_o
  );

endinterface

// File: rtl/bnn_binariser.sv
// bnn_binariser: threshold latch plus unsigned comparator.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   pix_i          grayscale pixel
//   thr_i          live threshold input
//   sample_i       latch thr_i (asserted on pixel 0 of a frame)
//   bit_o          pix_i >= threshold in force for this pixel
module bnn_binariser
  import bnn_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  pix_t pix_i,
  input  pix_t thr_i,
  input  logic sample_i,
  output logic bit_o
);

  pix_t thr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      thr_q <= '0;
    end else if (sample_i) begin
      thr_q <= thr_i;
    end
  end

  // Pixel 0 is compared against the value being latched, not the stale one.
  assign bit_o = (pix_i >= (sample_i ? thr_i : thr_q));

endmodule

// File: rtl/bnn_frame_loader.sv
// bnn_frame_loader: binarises an 8-bit pixel stream into 1x8x8 layers.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus            bnn_frame_loader_if.slave (pixel stream, layer handshake,
//                  frame error pulse, delivered-frame counter)
// Optional: define BNN_LOADER_DBUF_EN for a separate fill buffer so the next
// frame fills while the current one is held; default is a single buffer.
module bnn_frame_loader
  import bnn_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  bnn_frame_loader_if.slave       bus
);

  loader_state_e         state_q, state_d;
  pix_idx_t              idx_q, eff_idx;
  logic [FRAME_BITS-1:0] layer_q, fill_base, fill_next;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  pix_ready, layer_valid;
  logic                  accept, sample, frame_done, handshake, pix_bit;

  assign accept     = bus.pix_valid_i && pix_ready;
  // A sof pixel always lands at index 0, whatever the current fill position.
  assign eff_idx    = bus.pix_sof_i ? '0 : idx_q;
  assign sample     = accept && (eff_idx == '0);
  assign frame_done = accept && (eff_idx == pix_idx_t'(FRAME_BITS - 1));
  assign handshake  = layer_valid && bus.layer_ready_i;

  bnn_binariser u_binariser (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pix_i    (bus.pix_data_i),
    .thr_i    (bus.threshold_i),
    .sample_i (sample),
    .bit_o    (pix_bit)
  );

`ifdef BNN_LOADER_DBUF_EN
  logic [FRAME_BITS-1:0] fill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= '0;
    end else if (accept) begin
      fill_q <= fill_next;
    end
  end

  assign fill_base = fill_q;
`else
  assign fill_base = layer_q;
`endif

  always_comb begin
    fill_next          = fill_base;
    fill_next[eff_idx] = pix_bit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // A completion coinciding with a handshake keeps HOLD so valid has no bubble;
  // in single-buffer mode no pixel is accepted in HOLD, so that case never occurs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (frame_done) state_d = HOLD;
      HOLD: if (handshake)  state_d = frame_done ? HOLD : FILL;
      default:              state_d = FILL;
    endcase
  end

  always_comb begin
    pix_ready   = 1'b1;
    layer_valid = 1'b0;
    case (state_q)
      FILL: begin
        pix_ready = 1'b1;
      end
      HOLD: begin
        layer_valid = 1'b1;
`ifdef BNN_LOADER_DBUF_EN
        // Stall only on the last pixel, and only if the held frame is not leaving now.
        pix_ready = !((idx_q == pix_idx_t'(FRAME_BITS - 1)) && !bus.layer_ready_i);
`else
        pix_ready = 1'b0;
`endif
      end
      default: begin
        pix_ready = 1'b1;
      end
    endcase
  end

  // Index wraps to 0 after the last pixel, so no explicit clear on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      layer_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && bus.pix_sof_i && (idx_q != '0);
      if (accept) begin
        idx_q <= eff_idx + pix_idx_t'(1);
      end
      if (handshake) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`ifdef BNN_LOADER_DBUF_EN
      if (frame_done) begin
        layer_q <= fill_next;
      end
`else
      if (accept) begin
        layer_q <= fill_next;
      end
`endif
    end
  end

  assign bus.pix_ready_o   = pix_ready;
  assign bus.layer_valid_o = layer_valid;
  assign bus.layer_o       = layer_in_t'(layer_q);
  assign bus.frame_err_o   = err_q;
  assign bus.frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_bnn_frame_loader.sv
// tb_bnn_frame_loader: directed self-checking bench for bnn_frame_loader.
// Inputs change and outputs are sampled on the falling clock edge.
// Define BNN_LOADER_DBUF_EN to build against the double-buffered loader.
module tb_bnn_frame_loader;
  import bnn_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   drops;

  bnn_frame_loader_if bus ();

  bnn_frame_loader dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one pixel, wait (bounded) for the loader to take it, return on a falling edge.
  task automatic applyStimulus(input pix_t data, input logic sof);
    int waited;
    bus.pix_data_i  = data;
    bus.pix_sof_i   = sof;
    bus.pix_valid_i = 1'b1;
    waited = 0;
    while (!bus.pix_ready_o && waited < 200) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) checkOutput("pix_ready_timeout", 64'(bus.pix_ready_o), 64'(1));
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    bus.pix_sof_i   = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_layer"}, 64'(bus.layer_o), 64'h0);
    checkOutput({tag, "_valid"}, 64'(bus.layer_valid_o), 64'(0));
    checkOutput({tag, "_ready"}, 64'(bus.pix_ready_o), 64'(1));
    checkOutput({tag, "_err"},   64'(bus.frame_err_o), 64'(0));
    checkOutput({tag, "_cnt"},   64'(bus.frame_cnt_o), 64'(0));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drops = 0;
    rst_n = 1'b0;
    bus.pix_data_i    = '0;
    bus.pix_sof_i     = 1'b0;
    bus.pix_valid_i   = 1'b0;
    bus.threshold_i   = '0;
    bus.layer_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0..63 against 32: upper half ones.
    bus.threshold_i   = 8'd32;
    bus.layer_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) applyStimulus(pix_t'(i), i == 0);
    checkOutput("ramp_valid", 64'(bus.layer_valid_o), 64'(1));
    checkOutput("ramp_layer", 64'(bus.layer_o), 64'hFFFF_FFFF_0000_0000);
    @(negedge clk);
    checkOutput("ramp_cnt", 64'(bus.frame_cnt_o), 64'(1));
    checkOutput("ramp_valid_drop", 64'(bus.layer_valid_o), 64'(0));

    // Back-pressure: alternating pixels held for 20 cycles.
    bus.threshold_i   = 8'h80;
    bus.layer_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) applyStimulus((i % 2 == 1) ? 8'hFF : 8'h00, 1'b0);
    checkOutput("bp_valid", 64'(bus.layer_valid_o), 64'(1));
    checkOutput("bp_layer", 64'(bus.layer_o), 64'hAAAA_AAAA_AAAA_AAAA);
    repeat (20) @(negedge clk);
    checkOutput("bp_layer_stable", 64'(bus.layer_o), 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("bp_valid_stable", 64'(bus.layer_valid_o), 64'(1));
    checkOutput("bp_cnt_stable", 64'(bus.frame_cnt_o), 64'(1));
`ifndef BNN_LOADER_DBUF_EN
    checkOutput("bp_pix_ready_low", 64'(bus.pix_ready_o), 64'(0));
`endif
    bus.layer_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_cnt_inc", 64'(bus.frame_cnt_o), 64'(2));
    checkOutput("bp_pix_ready_back", 64'(bus.pix_ready_o), 64'(1));
    checkOutput("bp_valid_drop", 64'(bus.layer_valid_o), 64'(0));

    // Realignment: 10 pixels, then a sof pixel of 0xFF.
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b0);
    checkOutput("align_no_err_yet", 64'(bus.frame_err_o), 64'(0));
    applyStimulus(8'hFF, 1'b1);
    checkOutput("align_err_pulse", 64'(bus.frame_err_o), 64'(1));
    applyStimulus(8'h00, 1'b0);
    checkOutput("align_err_one_cycle", 64'(bus.frame_err_o), 64'(0));
    for (int i = 0; i < 62; i++) applyStimulus(8'h00, 1'b0);
    checkOutput("align_valid", 64'(bus.layer_valid_o), 64'(1));
    checkOutput("align_layer", 64'(bus.layer_o), 64'h0000_0000_0000_0001);
    @(negedge clk);
    checkOutput("align_cnt", 64'(bus.frame_cnt_o), 64'(3));

    // Threshold raised mid-frame is ignored.
    for (int i = 0; i < 64; i++) begin
      bus.threshold_i = (i < 5) ? 8'h10 : 8'hF0;
      applyStimulus(8'h80, 1'b0);
    end
    checkOutput("thr_latch_layer", 64'(bus.layer_o), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    checkOutput("thr_latch_cnt", 64'(bus.frame_cnt_o), 64'(4));

    // Reset at pixel 40.
    bus.threshold_i = 8'h40;
    for (int i = 0; i < 40; i++) applyStimulus(pix_t'(i * 4), 1'b0);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_mid_fill");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame into HOLD, then reset mid-HOLD.
    bus.layer_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) applyStimulus(pix_t'(i * 4), 1'b0);
    checkOutput("post_rst_layer", 64'(bus.layer_o), 64'hFFFF_FFFF_FFFF_0000);
    checkOutput("post_rst_valid", 64'(bus.layer_valid_o), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    bus.threshold_i   = 8'd32;
    bus.layer_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) applyStimulus(pix_t'(i), 1'b0);
    checkOutput("recover_layer", 64'(bus.layer_o), 64'hFFFF_FFFF_0000_0000);
    @(negedge clk);
    checkOutput("recover_cnt", 64'(bus.frame_cnt_o), 64'(1));

`ifdef BNN_LOADER_DBUF_EN
    // Three back-to-back frames with the consumer always ready.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.threshold_i   = 8'h80;
    bus.layer_ready_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) begin
        if (!bus.pix_ready_o) drops++;
        if (f == 0)      applyStimulus(8'hFF, 1'b0);
        else if (f == 1) applyStimulus(8'h00, 1'b0);
        else             applyStimulus((i % 2 == 1) ? 8'hFF : 8'h00, 1'b0);
      end
      checkOutput("dbuf_valid", 64'(bus.layer_valid_o), 64'(1));
      checkOutput("dbuf_cnt_before", 64'(bus.frame_cnt_o), 64'(f));
      if (f == 0)      checkOutput("dbuf_layer0", 64'(bus.layer_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else if (f == 1) checkOutput("dbuf_layer1", 64'(bus.layer_o), 64'h0);
      else             checkOutput("dbuf_layer2", 64'(bus.layer_o), 64'hAAAA_AAAA_AAAA_AAAA);
    end
    @(negedge clk);
    checkOutput("dbuf_cnt", 64'(bus.frame_cnt_o), 64'(3));
    checkOutput("dbuf_no_ready_drop", 64'(drops), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
